mem_stage_ctrl: RTL and testbench

Memory-stage sequencer that sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It drives the variable-latency data memory, which uses a request/stall/done handshake. It stalls the upstream pipeline while an access is in flight. It presents load data plus a one-cycle valid to the MEM/WB register. It detects misaligned accesses and memory timeouts, and both are latched as a sticky error.

---
 rtl/mem_stage_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer between EX/MEM and MEM/WB.
// Issues one data-memory access at a time over a request/stall/done handshake,
// holds the upstream pipeline while the access is in flight, and hands load
// data plus a one-cycle valid to MEM/WB. Misaligned accesses and accesses that
// never complete park the block in a sticky error state until reset.
module mem_stage_ctrl #(
    parameter int TIMEOUT     = 32,  // cycles allowed in REQ+WAIT per access (2..63)
    parameter int ALIGN_CHECK = 1    // nonzero: odd byte address on load/store is an error
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [15:0] ex_address,
    input  logic [15:0] ex_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        pipe_stall,
    output logic        wb_valid,
    output logic [15:0] data_read,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    // Counter value seen in the last cycle an access may still complete.
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;
    logic [15:0] r_rdata;
    logic        r_nm_valid;

    logic        w_is_mem;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;

    assign w_is_mem  = ex_mem_read | ex_mem_write;
    assign w_timeout = (r_cnt == TO_LAST);

    // Next-state decode; done wins over timeout in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_valid && w_is_mem) begin
                    if ((ALIGN_CHECK != 0) && ex_address[0]) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_REQ;
                        w_accept     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (!mem_stall && mem_done) begin
                    w_state_next = S_RESP;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end else if (!mem_stall) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    w_state_next = S_RESP;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Latch the request on accept so the memory sees stable address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= ex_address;
            r_wdata <= ex_wdata;
            r_wr    <= ex_mem_write;  // read+write together is a store
        end
    end

    // Per-access cycle counter, saturating at its 6-bit maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 6'd0;
        end else if (w_accept) begin
            r_cnt <= 6'd0;
        end else if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt != 6'h3F) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // Load data is captured on the edge that enters RESP; stores leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_rdata <= 16'h0000;
        else if (w_capture && !r_wr) r_rdata <= mem_rdata;
    end

    // Non-memory instructions complete one cycle after acceptance, without stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_nm_valid <= 1'b0;
        else     r_nm_valid <= (r_state == S_IDLE) && ex_valid && !w_is_mem;
    end

    assign mem_en     = (r_state == S_REQ);
    assign mem_wr     = mem_en & r_wr;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign pipe_stall = (r_state != S_IDLE);
    assign wb_valid   = (r_state == S_RESP) | r_nm_valid;
    assign data_read  = r_rdata;
    assign err        = (r_state == S_ERR);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios with a
// scoreboard of expected data_read values, popped on every wb_valid pulse.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [15:0] ex_address;
    logic [15:0] ex_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        pipe_stall;
    logic        wb_valid;
    logic [15:0] data_read;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] sb_q[$];
    logic [15:0] model_dr;

    mem_stage_ctrl #(
        .TIMEOUT    (32),
        .ALIGN_CHECK(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_mem_write(ex_mem_write),
        .ex_address  (ex_address),
        .ex_wdata    (ex_wdata),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_stall   (mem_stall),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .pipe_stall  (pipe_stall),
        .wb_valid    (wb_valid),
        .data_read   (data_read),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every completed instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                chk("data_read", 32'(data_read), 32'(e));
                $display("wb_valid: data_read=0x%04h expected=0x%04h", data_read, e);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_dr = 16'h0000;
    endtask

    // One memory access: stall_n cycles of mem_stall in REQ, then wait_n WAIT
    // cycles with done on the last one (wait_n == 0: done in REQ).
    task automatic do_mem(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int stall_n, input int wait_n,
                          input logic [15:0] rdata);
        logic [15:0] e;
        e = wr ? model_dr : rdata;
        model_dr = e;
        sb_q.push_back(e);
        $display("issue rd=%0b wr=%0b addr=0x%04h wdata=0x%04h stall=%0d wait=%0d",
                 rd, wr, addr, wdata, stall_n, wait_n);
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_address = addr; ex_wdata = wdata;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_address = 16'hFFFF; ex_wdata = 16'hFFFF;
        for (int i = 0; i <= stall_n; i++) begin
            chk("req_mem_en", 32'(mem_en), 32'd1);
            chk("req_addr", 32'(mem_addr), 32'(addr));
            chk("req_wr", 32'(mem_wr), 32'(wr));
            if (wr) chk("req_wdata", 32'(mem_wdata), 32'(wdata));
            chk("req_stall", 32'(pipe_stall), 32'd1);
            mem_stall = (i < stall_n);
            mem_done  = (i == stall_n) && (wait_n == 0);
            mem_rdata = rdata;
            @(negedge clk);
        end
        mem_stall = 1'b0;
        for (int j = 0; j < wait_n; j++) begin
            chk("wait_mem_en", 32'(mem_en), 32'd0);
            chk("wait_stall", 32'(pipe_stall), 32'd1);
            mem_done = (j == wait_n - 1);
            @(negedge clk);
        end
        mem_done = 1'b0; mem_rdata = 16'h0000;
        chk("resp_wb_valid", 32'(wb_valid), 32'd1);
        chk("resp_mem_en", 32'(mem_en), 32'd0);
        chk("resp_stall", 32'(pipe_stall), 32'd1);
        @(negedge clk);
        chk("post_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_stall", 32'(pipe_stall), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_address = 16'h0000; ex_wdata = 16'h0000;
        mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0000;
        model_dr = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data_read", 32'(data_read), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of an outstanding load.
        $display("reset mid-WAIT load 0x0010");
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_address = 16'h0010;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        chk("mw_mem_en", 32'(mem_en), 32'd1);
        chk("mw_addr", 32'(mem_addr), 32'h0010);
        @(negedge clk);
        chk("mw_wait_en", 32'(mem_en), 32'd0);
        chk("mw_wait_stall", 32'(pipe_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mw_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mw_rst_stall", 32'(pipe_stall), 32'd0);
        chk("mw_rst_wb", 32'(wb_valid), 32'd0);
        chk("mw_rst_err", 32'(err), 32'd0);
        chk("mw_rst_dr", 32'(data_read), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_dr = 16'h0000;
        @(negedge clk);

        // Fastest load, then a stalled store, then read+write treated as store.
        do_mem(1'b1, 1'b0, 16'h0024, 16'h0000, 0, 0, 16'hBEEF);
        do_mem(1'b0, 1'b1, 16'h00A2, 16'h1234, 3, 2, 16'h5555);
        do_mem(1'b1, 1'b1, 16'h0030, 16'h7777, 0, 1, 16'h6666);
        do_mem(1'b1, 1'b0, 16'h0102, 16'h0000, 1, 3, 16'hC0DE);

        // Back-to-back non-memory instructions.
        $display("four non-memory ops");
        for (int i = 0; i <= 4; i++) begin
            if (i >= 1) begin
                chk("nm_wb_valid", 32'(wb_valid), 32'd1);
                chk("nm_stall", 32'(pipe_stall), 32'd0);
                chk("nm_mem_en", 32'(mem_en), 32'd0);
            end
            if (i < 4) begin
                sb_q.push_back(model_dr);
                ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
                ex_address = 16'(i * 3);
            end else begin
                ex_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("nm_wb_after", 32'(wb_valid), 32'd0);

        // Misaligned load: sticky error, memory responses ignored.
        $display("misaligned load 0x0013");
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_address = 16'h0013;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mis_err", 32'(err), 32'd1);
            chk("mis_stall", 32'(pipe_stall), 32'd1);
            chk("mis_mem_en", 32'(mem_en), 32'd0);
            mem_done = i[0];
            mem_rdata = 16'hDEAD;
            @(negedge clk);
        end
        mem_done = 1'b0;
        chk("mis_dr_kept", 32'(data_read), 32'(model_dr));
        do_reset();

        // Load that never completes must time out after exactly 32 cycles.
        $display("timeout load 0x0040");
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_address = 16'h0040;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        n = 0;
        while (pipe_stall && !err && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", 32'(n), 32'd32);
        chk("to_err", 32'(err), 32'd1);
        chk("to_mem_en", 32'(mem_en), 32'd0);
        do_reset();

        // Done in the final allowed cycle beats the timeout.
        $display("load 0x0040 done on final cycle");
        sb_q.push_back(16'h5A5A);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_address = 16'h0040;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            mem_done  = (i == 32);
            mem_rdata = 16'h5A5A;
            @(negedge clk);
        end
        mem_done = 1'b0;
        chk("last_wb_valid", 32'(wb_valid), 32'd1);
        chk("last_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("last_err_after", 32'(err), 32'd0);
        chk("last_dr", 32'(data_read), 32'h5A5A);
        @(negedge clk);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
